// File: rtl/bram_port_arbiter.sv
// Round-robin req/ack arbiter sharing one block-RAM port between requesters m0 and m1.
// Define BRAM_ARB_BURST_EN to let a requester keep the port for up to MAX_BURST grants in a row.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_dout,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_dout,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  grant
);

  if (MAX_BURST < 1) begin : g_max_burst_check
    $error("bram_port_arbiter: MAX_BURST must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t                state, state_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  grant_nxt, busy_nxt, win;
  logic                  ram_we_nxt, m0_ack_nxt, m1_ack_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr_nxt;
  logic [DATA_WIDTH-1:0] ram_din_nxt, m0_dout_nxt, m1_dout_nxt;

`ifdef BRAM_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);
  // burst_cnt == 0 only after reset, meaning nobody has been served yet
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
`endif

  // Arbitration winner, only meaningful in IDLE with at least one request
  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) begin
`ifdef BRAM_ARB_BURST_EN
      win = (burst_cnt != '0 && burst_cnt < MAXB) ? last_grant : ~last_grant;
`else
      win = ~last_grant;
`endif
    end else if (m0_req) begin
      win = 1'b0;
    end else begin
      win = 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    ram_we_nxt     = ram_we;
    ram_addr_nxt   = ram_addr;
    ram_din_nxt    = ram_din;
    m0_ack_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m0_dout_nxt    = m0_dout;
    m1_dout_nxt    = m1_dout;
`ifdef BRAM_ARB_BURST_EN
    burst_cnt_nxt  = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt      = ISSUE;
          grant_nxt      = win;
          last_grant_nxt = win;
          ram_we_nxt     = win ? m1_we   : m0_we;
          ram_addr_nxt   = win ? m1_addr : m0_addr;
          ram_din_nxt    = win ? m1_din  : m0_din;
`ifdef BRAM_ARB_BURST_EN
          if (win == last_grant)
            burst_cnt_nxt = (burst_cnt < MAXB) ? burst_cnt + CW'(1) : burst_cnt;
          else
            burst_cnt_nxt = CW'(1);
`endif
        end
      end
      ISSUE: begin
        ram_we_nxt = 1'b0;
        state_nxt  = CAPTURE;
      end
      CAPTURE: begin
        if (grant) begin
          m1_dout_nxt = ram_dout;
          m1_ack_nxt  = 1'b1;
        end else begin
          m0_dout_nxt = ram_dout;
          m0_ack_nxt  = 1'b1;
        end
        state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        ram_we_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // last_grant resets to 1 so m0 wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      busy       <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_dout    <= '0;
      m1_dout    <= '0;
`ifdef BRAM_ARB_BURST_EN
      burst_cnt  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
      busy       <= busy_nxt;
      ram_we     <= ram_we_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_din    <= ram_din_nxt;
      m0_ack     <= m0_ack_nxt;
      m1_ack     <= m1_ack_nxt;
      m0_dout    <= m0_dout_nxt;
      m1_dout    <= m1_dout_nxt;
`ifdef BRAM_ARB_BURST_EN
      burst_cnt  <= burst_cnt_nxt;
`endif
    end
  end

endmodule
